// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with request lock.
// The optional hold limit is enabled by defining RR_ARB_HOLD_LIMIT_EN.
package rr_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // OR-reduction of set-bit positions; exact for one-hot or all-zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotated priority encoder: scans req starting just after ptr,
// wrapping modulo N_REQ, optionally skipping one excluded index.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             exclude_en,
    input  logic [IDX_W-1:0] exclude_idx,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    localparam logic [IDX_W:0] N_WIDE = (IDX_W + 1)'(N_REQ);

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] cand_hit;
    logic [IDX_W-1:0] cand_idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_eligible
            assign eligible[gi] = req[gi] && !(exclude_en && (exclude_idx == IDX_W'(gi)));
        end

        // Candidate gi is the requester visited at position gi of the rotated scan.
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            logic [IDX_W:0] wrapped;
            assign sum          = {1'b0, ptr} + (IDX_W + 1)'(gi + 1);
            assign wrapped      = sum - N_WIDE;
            assign cand_idx[gi] = (sum >= N_WIDE) ? wrapped[IDX_W-1:0] : sum[IDX_W-1:0];
            assign cand_hit[gi] = eligible[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found  = |cand_hit;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter_with_lock.sv
// Round-robin arbiter whose grant stays locked to the owner while it requests.
// Define RR_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles of ownership.
module round_robin_arbiter_with_lock #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);
    import rr_arb_pkg::*;

    generate
        if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_HOLD < 2) begin : g_param_check
            $error("round_robin_arbiter_with_lock: illegal N_REQ or MAX_HOLD");
        end
    endgenerate

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic             grant_valid_reg, grant_valid_next;
    logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [3:0]       pick_idx_full;
    logic             exclude_en;
    logic             hold_expired;
    logic             take_new;

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req         (req),
        .ptr         (ptr_reg),
        .exclude_en  (exclude_en),
        .exclude_idx (grant_idx_reg),
        .found       (pick_found),
        .winner      (pick_idx)
    );

    assign pick_onehot   = N_REQ'(1) << pick_idx;
    assign pick_idx_full = onehot_to_idx(MAX_REQ'(pick_onehot));

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_next       = grant_reg;
        grant_valid_next = grant_valid_reg;
        grant_idx_next   = grant_idx_reg;
        take_new         = 1'b0;

        case (state_reg)
            IDLE: begin
                take_new = pick_found;
            end
            OWNED: begin
                if (!req[grant_idx_reg]) begin
                    // Release: hand off with no bubble, or fall back to idle.
                    if (pick_found) begin
                        take_new = 1'b1;
                    end else begin
                        state_next       = IDLE;
                        grant_next       = '0;
                        grant_valid_next = 1'b0;
                    end
                end else if (hold_expired && pick_found) begin
                    take_new = 1'b1;
                end
            end
            default: begin
                state_next       = IDLE;
                grant_next       = '0;
                grant_valid_next = 1'b0;
            end
        endcase

        if (take_new) begin
            state_next       = OWNED;
            ptr_next         = pick_idx;
            grant_next       = pick_onehot;
            grant_valid_next = 1'b1;
            grant_idx_next   = pick_idx_full[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= IDX_W'(N_REQ - 1);
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            grant_valid_reg <= grant_valid_next;
            grant_idx_reg   <= grant_idx_next;
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;

    // The owner is skipped while searching so a lone requester keeps the grant.
    assign exclude_en   = (state_reg == OWNED);
    assign hold_expired = (state_reg == OWNED) && (hold_reg == HOLD_LAST);

    always_comb begin
        hold_next = hold_reg;
        if (take_new || state_next != OWNED) begin
            hold_next = '0;
        end else if (hold_reg != HOLD_LAST) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end
`else
    assign exclude_en   = 1'b0;
    assign hold_expired = 1'b0;
`endif

    assign grant       = grant_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_round_robin_arbiter_with_lock.sv
// Scoreboard bench for round_robin_arbiter_with_lock (N_REQ=4, MAX_HOLD=8);
// expectations follow RR_ARB_HOLD_LIMIT_EN when it is defined.
module tb_round_robin_arbiter_with_lock;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;

    round_robin_arbiter_with_lock #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic         v;
        logic [1:0]   idx;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: owner (-1 when idle), last winner, ownership length.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_last;

    function automatic int search(input logic [N-1:0] q, input int from, input int skip);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (q[i] && i != skip) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic r, input logic [N-1:0] q);
        int pick;
        if (r) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_hold  = 0;
            m_last  = 0;
            return;
        end
        pick = -1;
        if (m_owner < 0) begin
            pick = search(q, m_ptr, -1);
        end else if (!q[m_owner]) begin
            pick = search(q, m_ptr, -1);
            if (pick < 0) m_owner = -1;
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            if (m_hold == MAX_HOLD - 1) pick = search(q, m_ptr, m_owner);
`endif
        end
        if (pick >= 0) begin
            m_owner = pick;
            m_ptr   = pick;
            m_last  = pick;
            m_hold  = 0;
        end else if (m_owner >= 0) begin
            m_hold = (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
        end
    endfunction

    task automatic step(input logic r, input logic [N-1:0] q, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = q;
        model_step(r, q);
        e.g   = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.v   = (m_owner >= 0);
        e.idx = 2'(m_last);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per clock once stimulus has been queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (grant !== e.g || grant_valid !== e.v || grant_idx !== e.idx) begin
                miscompares++;
                $display("FAIL %s t=%0t: grant=%b valid=%b idx=%0d, required grant=%b valid=%b idx=%0d",
                         e.tag, $time, grant, grant_valid, grant_idx, e.g, e.v, e.idx);
            end else begin
                $display("ok   %s t=%0t: req=%b grant=%b valid=%b idx=%0d",
                         e.tag, $time, req, grant, grant_valid, grant_idx);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        rst = 1'b1;
        req = '0;
        m_owner = -1;
        m_ptr   = N - 1;
        m_hold  = 0;
        m_last  = 0;

        step(1'b1, 4'b0000, "reset");
        step(1'b1, 4'b0000, "reset");
        repeat (5) step(1'b0, 4'b0000, "idle");

        // Each owner drops its request for one cycle after three cycles of ownership.
        for (int o = 0; o < N; o++) begin
            repeat (3) step(1'b0, 4'b1111, "rotate");
            step(1'b0, 4'b1111 & ~(4'b0001 << o), "rotate_release");
        end
        step(1'b0, 4'b1111, "rotate_wrap");
        repeat (2) step(1'b0, 4'b0000, "rotate_drain");

        repeat (4) step(1'b0, 4'b0100, "single_req2");
        repeat (3) step(1'b0, 4'b0000, "single_req2_idle");

        repeat (2) step(1'b0, 4'b0010, "owner1");
        step(1'b0, 4'b1011, "owner1_pending");
        step(1'b0, 4'b1001, "owner1_release");
        step(1'b0, 4'b1001, "owner3");
        step(1'b0, 4'b0001, "owner3_release");
        repeat (2) step(1'b0, 4'b0000, "owner_drain");

        for (int t = 0; t < 4; t++) step(1'b0, (t % 2 == 0) ? 4'b0001 : 4'b0000, "toggle0");

        repeat (2) step(1'b0, 4'b0001, "hold0");
        repeat (12) step(1'b0, 4'b0011, "hold_contend");
        repeat (2) step(1'b0, 4'b0000, "hold_drain");

        repeat (2) step(1'b0, 4'b0100, "pre_reset");
        step(1'b1, 4'b0100, "mid_reset");
        step(1'b0, 4'b0110, "post_reset");
        step(1'b0, 4'b0110, "post_reset");

        rq = '0;
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0] flip;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
            rq = rq ^ flip;
            step(($urandom_range(0, 63) == 0), rq, "random");
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
